decodificador_gray_cond: RTL and testbench
==========================================

Name: decodificador_gray_cond

Overview:
- Receiving end of the conditional Gray counter link: samples a Gray-coded count on `enable` and decodes it to binary.
- Checks that each sample is exactly the previous value +1 (mod 2^WIDTH).
- Runs a lock state machine and reports sequence errors with a pulse and a saturating error counter.
- Sits downstream of the Gray counter; its `enable` is the same qualifier that advances the counter.

Parameters:
- WIDTH, 5, width of the Gray code and of the decoded binary value (count range 0..2^WIDTH-1).
- LOCK_COUNT, 4, consecutive correct increments required to enter lock; must be >= 1.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_L  input  1  synchronous, active-high reset.
- enable  input  1  sample strobe; `gray_in` is evaluated only when high.
- gray_in  input  WIDTH  incoming Gray-coded count.
- binario  output  WIDTH  registered binary decode of the last sampled `gray_in`.
- valido  output  1  one-cycle pulse: `binario` was updated on this edge.
- sincronizado  output  1  high while the FSM is in BLOQUEADO.
- error  output  1  one-cycle pulse: sequence break detected while locked.
- cuenta_errores  output  ERR_W  count of errors; saturates at 2^ERR_W-1.

Behaviour:
- Reset (`reset_L`=1 at a rising edge):
  - state=VACIO, racha=0, previous-reference register=0.
  - `binario`=0, `valido`=0, `sincronizado`=0, `error`=0, `cuenta_errores`=0.
  - Reset has priority over `enable`. Mid-operation it clears everything, including the error count.
- Decode:
  - bin[WIDTH-1]=g[WIDTH-1].
  - bin[i]=bin[i+1]^g[i] for i from WIDTH-2 down to 0.
  - Purely combinational from `gray_in`; the result is registered.
- Latency:
  - Sample taken at edge N when `enable`=1.
  - `binario`, `valido`, `error`, `sincronizado` and `cuenta_errores` all reflect that sample after edge N (one cycle).
- `enable`=0:
  - No state change; `binario`, `sincronizado` and `cuenta_errores` hold.
  - `valido`=0 and `error`=0.
  - `gray_in` is ignored.
- Every enabled sample:
  - `binario`<=decoded value, `valido`<=1.
  - Reference register <= decoded value.
- Match rule: match = (decoded == reference+1 mod 2^WIDTH). The wrap 2^WIDTH-1 -> 0 is a match.
- A repeated value under `enable` is a mismatch.
- FSM:
  - VACIO: on enable -> ADQUIRIR, racha=0. The first sample is only the reference; no check.
  - ADQUIRIR, on enable:
    - Match: racha++. If racha reaches LOCK_COUNT on this edge -> BLOQUEADO, `sincronizado`=1 on the same edge.
    - Mismatch: racha=0, stay in ADQUIRIR. No `error` pulse and no counter increment.
  - BLOQUEADO, on enable:
    - Match: stay.
    - Mismatch: `error`=1 for one cycle, `cuenta_errores` += 1 (saturating), -> ADQUIRIR, racha=0, `sincronizado`=0 on the same edge.
    - The offending sample becomes the new reference.
- racha width: enough bits to hold LOCK_COUNT.
- Error counter at max with a new error: `error` still pulses; the count stays at max.

Decomposition:
- Package `gray_pkg`:
  - FSM state enum {VACIO, ADQUIRIR, BLOQUEADO}.
  - Function `gray_a_binario(WIDTH)`.
  - Function `binario_a_gray` (bench use, matches the encoder formula b^(b>>1)).
- One natural sub-module: `gray_a_bin_comb`, the parameterised combinational XOR-chain decoder, instantiated once.
- The FSM, match compare, racha counter and saturating error counter live in the top module.

Test Plan:
1. Reset, then `enable`=1 continuously with gray(0),gray(1),...,gray(31),gray(0),gray(1) (WIDTH=5, LOCK_COUNT=4) -> `binario` follows 0..31,0,1 one cycle late with `valido`=1 each cycle; `sincronizado` rises with `binario`=4; the 31->0 wrap gives no error.
2. While locked, send gray(10) then gray(12) -> `binario`=12, `error`=1 for one cycle, `cuenta_errores`=1, `sincronizado`=0; relocks when `binario`=16 after gray(13..16).
3. While locked, deassert `enable` for 3 cycles with `gray_in`=gray(7) garbage, then resume the correct sequence -> `binario` holds, `valido`=0 during the gap, no error, lock is kept.
4. While locked, present the same code twice with `enable`=1 (gray(20),gray(20)) -> second sample: `error`=1, `cuenta_errores` increments, state goes to ADQUIRIR.
5. ERR_W=2: force 5 locked-state errors, relocking between them -> `error` pulses 5 times; `cuenta_errores` goes 1,2,3,3,3.
6. Locked with `cuenta_errores`=2, assert `reset_L`=1 for one cycle while `enable`=1 -> next cycle all outputs 0 and state VACIO. The next enabled sample gives `valido`=1, no error, `sincronizado`=0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code receive path.
// Holds the lock FSM state enum and Gray/binary conversion functions.
package gray_pkg;

    typedef enum logic [1:0] {
        VACIO     = 2'd0,
        ADQUIRIR  = 2'd1,
        BLOQUEADO = 2'd2
    } estado_t;

    localparam int MAX_W = 32;

    // Prefix XOR from the MSB down; bits above width are masked off first.
    function automatic logic [MAX_W-1:0] gray_a_binario(input logic [MAX_W-1:0] g,
                                                        input int width);
        logic [MAX_W-1:0] masked;
        logic [MAX_W-1:0] b;
        masked = g & ((width >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << width) - MAX_W'(1)));
        b = masked;
        for (int i = 1; i < MAX_W; i++) begin
            b = b ^ (masked >> i);
        end
        return b;
    endfunction

    function automatic logic [MAX_W-1:0] binario_a_gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_a_bin_comb.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR
// of all Gray bits at or above its position.
module gray_a_bin_comb #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Reduction per bit rather than a bit-to-bit chain keeps the net graph acyclic.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_xor
            assign bin[gi] = ^gray[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/decodificador_gray_cond.sv
// Gray-count receiver: decodes enabled samples, checks for +1 steps,
// tracks lock and counts (saturating) sequence breaks seen while locked.
module decodificador_gray_cond
    import gray_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enable,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] binario,
    output logic             valido,
    output logic             sincronizado,
    output logic             error,
    output logic [ERR_W-1:0] cuenta_errores
);

    localparam int RACHA_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

    estado_t            estado_reg, estado_next;
    logic [RACHA_W-1:0] racha_reg, racha_next;
    logic [WIDTH-1:0]   ref_reg, ref_next;
    logic [WIDTH-1:0]   binario_reg, binario_next;
    logic               valido_reg, valido_next;
    logic               error_reg, error_next;
    logic [ERR_W-1:0]   cuenta_reg, cuenta_next;

    logic [WIDTH-1:0]   decodificado;
    logic               coincide;
    logic [RACHA_W-1:0] racha_inc;

    gray_a_bin_comb #(
        .WIDTH(WIDTH)
    ) u_decod (
        .gray (gray_in),
        .bin  (decodificado)
    );

    // Natural wrap of the WIDTH-bit add makes max -> 0 a valid step.
    assign coincide  = (decodificado == WIDTH'(ref_reg + 1'b1));
    assign racha_inc = racha_reg + 1'b1;

    always_comb begin
        estado_next  = estado_reg;
        racha_next   = racha_reg;
        ref_next     = ref_reg;
        binario_next = binario_reg;
        valido_next  = 1'b0;
        error_next   = 1'b0;
        cuenta_next  = cuenta_reg;

        if (enable) begin
            binario_next = decodificado;
            valido_next  = 1'b1;
            ref_next     = decodificado;

            case (estado_reg)
                VACIO: begin
                    estado_next = ADQUIRIR;
                    racha_next  = '0;
                end
                ADQUIRIR: begin
                    if (coincide) begin
                        if (racha_inc == RACHA_W'(LOCK_COUNT)) begin
                            estado_next = BLOQUEADO;
                            racha_next  = '0;
                        end else begin
                            racha_next = racha_inc;
                        end
                    end else begin
                        racha_next = '0;
                    end
                end
                BLOQUEADO: begin
                    if (!coincide) begin
                        error_next  = 1'b1;
                        estado_next = ADQUIRIR;
                        racha_next  = '0;
                        if (cuenta_reg != {ERR_W{1'b1}}) begin
                            cuenta_next = cuenta_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    estado_next = VACIO;
                    racha_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_L) begin
            estado_reg  <= VACIO;
            racha_reg   <= '0;
            ref_reg     <= '0;
            binario_reg <= '0;
            valido_reg  <= 1'b0;
            error_reg   <= 1'b0;
            cuenta_reg  <= '0;
        end else begin
            estado_reg  <= estado_next;
            racha_reg   <= racha_next;
            ref_reg     <= ref_next;
            binario_reg <= binario_next;
            valido_reg  <= valido_next;
            error_reg   <= error_next;
            cuenta_reg  <= cuenta_next;
        end
    end

    assign binario        = binario_reg;
    assign valido         = valido_reg;
    assign error          = error_reg;
    assign cuenta_errores = cuenta_reg;
    assign sincronizado   = (estado_reg == BLOQUEADO);

endmodule

// File: tb/tb_decodificador_gray_cond.sv
// Scoreboard bench for decodificador_gray_cond: directed scenarios then random traffic,
// checked against a behavioural model of the lock/error rules.
module tb_decodificador_gray_cond;
    import gray_pkg::*;

    localparam int W    = 5;
    localparam int LC   = 4;
    localparam int EW   = 2;
    localparam int MODV = 1 << W;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          enable;
    logic [W-1:0]  gray_in;
    logic [W-1:0]  binario;
    logic          valido;
    logic          sincronizado;
    logic          error;
    logic [EW-1:0] cuenta_errores;

    decodificador_gray_cond #(
        .WIDTH      (W),
        .LOCK_COUNT (LC),
        .ERR_W      (EW)
    ) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .enable         (enable),
        .gray_in        (gray_in),
        .binario        (binario),
        .valido         (valido),
        .sincronizado   (sincronizado),
        .error          (error),
        .cuenta_errores (cuenta_errores)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  bin;
        logic          v;
        logic          s;
        logic          e;
        logic [EW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    // Behavioural model state
    int m_ref, m_streak, m_cnt, m_bin;
    bit m_started, m_locked;

    function automatic int gray_of(input int b);
        logic [31:0] gv;
        gv = binario_a_gray(32'(b % MODV));
        return int'(gv) % MODV;
    endfunction

    // Decode by search: the binary value whose Gray image equals the code.
    function automatic int decode_search(input int code);
        int d;
        d = 0;
        for (int b = 0; b < MODV; b++) begin
            if (((b ^ (b >> 1)) % MODV) == code) d = b;
        end
        return d;
    endfunction

    task automatic drive(input bit rst, input bit en, input int code);
        exp_t x;
        int   d;
        bit   v, e;
        @(negedge clk);
        reset_L = rst;
        enable  = en;
        gray_in = W'(code);
        v = 1'b0;
        e = 1'b0;
        if (rst) begin
            m_ref = 0; m_streak = 0; m_cnt = 0; m_bin = 0;
            m_started = 0; m_locked = 0;
        end else if (en) begin
            d = decode_search(code % MODV);
            v = 1'b1;
            if (!m_started) begin
                m_started = 1;
                m_streak  = 0;
            end else if (m_locked) begin
                if (d != (m_ref + 1) % MODV) begin
                    e = 1'b1;
                    m_cnt = (m_cnt + 1 > (1 << EW) - 1) ? (1 << EW) - 1 : m_cnt + 1;
                    m_locked = 0;
                    m_streak = 0;
                end
            end else if (d == (m_ref + 1) % MODV) begin
                m_streak++;
                if (m_streak >= LC) begin
                    m_locked = 1;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
            m_ref = d;
            m_bin = d;
        end
        x.bin = W'(m_bin);
        x.v   = v;
        x.s   = m_locked;
        x.e   = e;
        x.cnt = EW'(m_cnt);
        exp_q.push_back(x);
    endtask

    task automatic send(input int v);
        drive(1'b0, 1'b1, gray_of(v));
    endtask

    // Monitor: each clock, compare the DUT outputs with the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_x = exp_q.pop_front();
                checks++;
                txn++;
                if ({binario, valido, sincronizado, error, cuenta_errores} !== mon_x) begin
                    failures++;
                    $display("FAIL txn%0d outputs: got bin=%0d v=%0b s=%0b e=%0b cnt=%0d, want bin=%0d v=%0b s=%0b e=%0b cnt=%0d",
                             txn, binario, valido, sincronizado, error, cuenta_errores,
                             mon_x.bin, mon_x.v, mon_x.s, mon_x.e, mon_x.cnt);
                end else begin
                    $display("txn%0d bin=%0d v=%0b s=%0b e=%0b cnt=%0d",
                             txn, binario, valido, sincronizado, error, cuenta_errores);
                end
            end
        end
    end

    initial begin
        int r;
        reset_L = 1'b1;
        enable  = 1'b0;
        gray_in = '0;

        // Reset then full count with wrap
        drive(1'b1, 1'b0, 0);
        for (int i = 0; i < 34; i++) send(i);

        // Sequence break while locked, then relock
        for (int i = 2; i <= 10; i++) send(i);
        send(12);
        for (int i = 13; i <= 16; i++) send(i);

        // Enable gap with garbage input
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, gray_of(7));
        for (int i = 17; i <= 20; i++) send(i);

        // Repeated code is an error, then relock
        send(20);
        for (int i = 21; i <= 24; i++) send(i);

        // Reset mid-operation with enable high and count at 2
        drive(1'b1, 1'b1, gray_of(25));
        send(5);

        // Saturation: five locked errors with relock in between
        for (int i = 6; i <= 9; i++) send(i);
        for (int k = 0; k < 5; k++) begin
            send(m_ref + 2);
            for (int j = 0; j < LC; j++) send(m_ref + 1);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2)       drive(1'b1, 1'($urandom_range(0, 1)), gray_of($urandom_range(0, MODV - 1)));
            else if (r < 20) drive(1'b0, 1'b0, int'($urandom_range(0, MODV - 1)));
            else if (r < 28) send($urandom_range(0, MODV - 1));
            else             send(m_ref + 1);
        end

        // Drain, bounded
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
